lc3_control: RTL and testbench
==============================

LC3_CONTROL -- requirements
Module: lc3_control

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 2, extra wait cycles per memory access (range 0-7).
REQ-002 SHALL have port Clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port Run  input  1  start execution from HALTED.
REQ-005 SHALL have port Continue  input  1  resume from PAUSE states.
REQ-006 SHALL have port IR  input  16  instruction register from datapath.
REQ-007 SHALL have port BEN  input  1  branch enable from datapath.
REQ-008 SHALL have ports LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC  output  1 each  datapath load enables.
REQ-009 SHALL have ports GatePC, GateMDR, GateALU, GateMARMUX  output  1 each  bus drivers, at most one high per cycle.
REQ-010 SHALL have ports DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN  output  1 each  datapath selects.
REQ-011 SHALL have ports PCMUX, ADDR2MUX, ALUK  output  2 each  datapath selects.
REQ-012 SHALL have ports Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  output  1 each  SRAM strobes, active-low.

Function
REQ-013 SHALL be a Moore FSM; all outputs combinational from state only, default 0 for enables/selects, 1 for Mem_OE/Mem_WE; Mem_CE/Mem_UB/Mem_LB constant 0.
REQ-014 SHALL sit in HALTED until Run=1, then go to S18.
REQ-015 Fetch: S18 (GatePC, LD_MAR, PCMUX=00, LD_PC) -> S33 (MIO_EN, Mem_OE=0, LD_MDR) -> S35 (GateMDR, LD_IR) -> S32 (LD_BEN) -> execute per IR[15:12].
REQ-016 S33, S25 (load read) and S16 (store write) SHALL each last exactly MEM_WAIT+1 cycles via a wait counter cleared on state entry; MEM_WAIT=0 gives single-cycle states.
REQ-017 ADD(0001)/AND(0101): one state, GateALU, LD_REG, LD_CC, SR1MUX=1, SR2MUX=IR[5], ALUK 00/01, DRMUX=0; NOT(1001): same with ALUK=10.
REQ-018 BR(0000): S0; BEN=1 -> S22 (PCMUX=10, ADDR1MUX=0, ADDR2MUX=10, LD_PC); BEN=0 -> S18.
REQ-019 JMP(1100): S12, ADDR1MUX=1, ADDR2MUX=00, SR1MUX=1, PCMUX=10, LD_PC.
REQ-020 JSR(0100): S4 (GatePC, DRMUX=1, LD_REG) -> S21 (PCMUX=10, ADDR1MUX=0, ADDR2MUX=11, LD_PC); IR[11]=0 treated identically (JSRR not supported).
REQ-021 LDR(0110): S6 (GateMARMUX, ADDR1MUX=1, ADDR2MUX=01, SR1MUX=1, LD_MAR) -> S25 -> S27 (GateMDR, LD_REG, LD_CC, DRMUX=0).
REQ-022 STR(0111): S7 (as S6) -> S23 (SR1MUX=0, ALUK=11, GateALU, LD_MDR) -> S16 (Mem_WE=0) -> S18.
REQ-023 Every instruction's final state SHALL return to S18; unsupported opcodes SHALL go S32 -> S18 (NOP).
REQ-024 Run SHALL be sampled only in HALTED; Continue held high SHALL not skip more than one PAUSE state per assertion.

Reset
REQ-025 Reset SHALL asynchronously force HALTED and clear the wait counter, mid-access included; outputs reach REQ-013 defaults without a clock edge.
REQ-026 After Reset deasserts, no load enable SHALL assert before Run=1 is sampled.

Configuration
REQ-027 With LC3_PAUSE_EN defined: S35 -> PAUSE_IR1 (hold until Continue=1) -> PAUSE_IR2 (hold until Continue=0) -> S32, and opcode 1101 -> PAUSE1/PAUSE2 same handshake -> S18; without it: S35 -> S32 directly, 1101 is NOP.

Structure
REQ-028 Package lc3_ctrl_pkg SHALL hold the state enum, opcode constants, PCMUX/ADDR2MUX/ALUK encodings (PCMUX 00 PC+1, 01 BUS, 10 ADDR; ADDR2MUX 00 zero, 01 off6, 10 off9, 11 off11; ALUK 00 ADD, 01 AND, 10 NOT, 11 PASSA).
REQ-029 Wait counting SHALL live in sub-module mem_wait_timer (start, done, width 3).

Verification
REQ-030 Reset during S33 (MEM_WAIT=2, cycle 2) -> HALTED immediately, Mem_OE=1, no LD_MDR.
REQ-031 Run pulse, IR=0x1262 (ADD R1,R1,#2) -> S18,S33x3,S35,S32,ADD; LD_REG/LD_CC high one cycle, SR2MUX=1.
REQ-032 IR=0x0E05, BEN=1 -> S22 with LD_PC, PCMUX=10, ADDR2MUX=10; BEN=0 -> S18 next, no LD_PC.
REQ-033 IR=0x7042 (STR) MEM_WAIT=0 -> Mem_WE=0 exactly one cycle, Mem_OE stays 1.
REQ-034 LC3_PAUSE_EN, IR=0xD0FF -> holds PAUSE1 until Continue=1, PAUSE2 until Continue=0, then S18; undefined -> S32 -> S18.

Source files
------------

// File: rtl/lc3_control_pkg.sv
// rtl/lc3_control_pkg.sv - LC-3 control unit package: states, opcodes, mux encodings
package lc3_ctrl_pkg;

   typedef enum logic [4:0] {
      ST_HALTED,
      ST_S18, ST_S33, ST_S35, ST_S32,
      ST_S1, ST_S5, ST_S9,
      ST_S0, ST_S22,
      ST_S12,
      ST_S4, ST_S21,
      ST_S6, ST_S25, ST_S27,
      ST_S7, ST_S23, ST_S16,
      ST_PAUSE_IR1, ST_PAUSE_IR2,
      ST_PAUSE1, ST_PAUSE2
   } lc3_state_t;

   localparam logic [3:0] OP_BR    = 4'b0000;
   localparam logic [3:0] OP_ADD   = 4'b0001;
   localparam logic [3:0] OP_JSR   = 4'b0100;
   localparam logic [3:0] OP_AND   = 4'b0101;
   localparam logic [3:0] OP_LDR   = 4'b0110;
   localparam logic [3:0] OP_STR   = 4'b0111;
   localparam logic [3:0] OP_NOT   = 4'b1001;
   localparam logic [3:0] OP_JMP   = 4'b1100;
   localparam logic [3:0] OP_PAUSE = 4'b1101;

   localparam logic [1:0] PCMUX_PC1  = 2'b00;
   localparam logic [1:0] PCMUX_BUS  = 2'b01;
   localparam logic [1:0] PCMUX_ADDR = 2'b10;

   localparam logic [1:0] ADDR2_ZERO  = 2'b00;
   localparam logic [1:0] ADDR2_OFF6  = 2'b01;
   localparam logic [1:0] ADDR2_OFF9  = 2'b10;
   localparam logic [1:0] ADDR2_OFF11 = 2'b11;

   localparam logic [1:0] ALUK_ADD   = 2'b00;
   localparam logic [1:0] ALUK_AND   = 2'b01;
   localparam logic [1:0] ALUK_NOT   = 2'b10;
   localparam logic [1:0] ALUK_PASSA = 2'b11;

   // States that hold for MEM_WAIT+1 cycles while the SRAM access completes.
   function automatic logic is_wait_state(input lc3_state_t s);
      return (s == ST_S33) || (s == ST_S25) || (s == ST_S16);
   endfunction

endpackage

// File: rtl/lc3_control_if.sv
// rtl/lc3_control_if.sv - control unit <-> datapath/SRAM signal bundle
interface lc3_control_if;
   logic        Run;
   logic        Continue;
   logic [15:0] IR;
   logic        BEN;

   logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC;
   logic GatePC, GateMDR, GateALU, GateMARMUX;
   logic DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN;
   logic [1:0] PCMUX, ADDR2MUX, ALUK;
   logic Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

   modport master (
      input  Run, Continue, IR, BEN,
      output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
      output GatePC, GateMDR, GateALU, GateMARMUX,
      output DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN,
      output PCMUX, ADDR2MUX, ALUK,
      output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
   );

   modport slave (
      output Run, Continue, IR, BEN,
      input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
      input  GatePC, GateMDR, GateALU, GateMARMUX,
      input  DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN,
      input  PCMUX, ADDR2MUX, ALUK,
      input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
   );
endinterface

// File: rtl/lc3_control_mem_wait_timer.sv
// rtl/lc3_control_mem_wait_timer.sv - counts a memory state out to MEM_WAIT+1 cycles
module mem_wait_timer #(
   parameter int unsigned WIDTH    = 3,
   parameter int unsigned MEM_WAIT = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_start,
   output logic o_done
);
   localparam logic [WIDTH-1:0] LP_LAST = WIDTH'(MEM_WAIT);

   logic [WIDTH-1:0] r_count;

   assign o_done = i_start && (r_count == LP_LAST);

   // Clearing whenever the FSM is outside a wait state gives a fresh count on every entry.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (!i_start || o_done) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end
endmodule

// File: rtl/lc3_control.sv
// rtl/lc3_control.sv - LC-3 Moore control FSM; LC3_PAUSE_EN adds the Continue pause handshake
module lc3_control
   import lc3_ctrl_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 2
) (
   input logic           Clk,
   input logic           Reset,
   lc3_control_if.master bus
);
   lc3_state_t r_state;
   logic       w_wait_active;
   logic       w_wait_done;
   logic       w_unused;

   assign w_wait_active = is_wait_state(r_state);
   assign w_unused      = ^{bus.IR[11:6], bus.IR[4:0]};

   mem_wait_timer #(.WIDTH(3), .MEM_WAIT(MEM_WAIT)) u_timer (
      .i_clk   (Clk),
      .i_rst   (Reset),
      .i_start (w_wait_active),
      .o_done  (w_wait_done)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= ST_HALTED;
      end else begin
         case (r_state)
            ST_HALTED: if (bus.Run) r_state <= ST_S18;
            ST_S18:    r_state <= ST_S33;
            ST_S33:    if (w_wait_done) r_state <= ST_S35;
`ifdef LC3_PAUSE_EN
            ST_S35:    r_state <= ST_PAUSE_IR1;
`else
            ST_S35:    r_state <= ST_S32;
`endif
            ST_PAUSE_IR1: if (bus.Continue)  r_state <= ST_PAUSE_IR2;
            ST_PAUSE_IR2: if (!bus.Continue) r_state <= ST_S32;
            ST_S32: begin
               case (bus.IR[15:12])
                  OP_BR:    r_state <= ST_S0;
                  OP_ADD:   r_state <= ST_S1;
                  OP_AND:   r_state <= ST_S5;
                  OP_NOT:   r_state <= ST_S9;
                  OP_JMP:   r_state <= ST_S12;
                  OP_JSR:   r_state <= ST_S4;
                  OP_LDR:   r_state <= ST_S6;
                  OP_STR:   r_state <= ST_S7;
`ifdef LC3_PAUSE_EN
                  OP_PAUSE: r_state <= ST_PAUSE1;
`endif
                  default:  r_state <= ST_S18;
               endcase
            end
            ST_S0:     r_state <= bus.BEN ? ST_S22 : ST_S18;
            ST_S4:     r_state <= ST_S21;
            ST_S6:     r_state <= ST_S25;
            ST_S25:    if (w_wait_done) r_state <= ST_S27;
            ST_S7:     r_state <= ST_S23;
            ST_S23:    r_state <= ST_S16;
            ST_S16:    if (w_wait_done) r_state <= ST_S18;
            ST_PAUSE1: if (bus.Continue)  r_state <= ST_PAUSE2;
            ST_PAUSE2: if (!bus.Continue) r_state <= ST_S18;
            ST_S1, ST_S5, ST_S9, ST_S22, ST_S12, ST_S21, ST_S27:
                       r_state <= ST_S18;
            default:   r_state <= ST_HALTED;
         endcase
      end
   end

   // Pure state decode, so an asynchronous reset reaches the idle outputs immediately.
   always_comb begin
      bus.LD_MAR     = 1'b0;
      bus.LD_MDR     = 1'b0;
      bus.LD_IR      = 1'b0;
      bus.LD_BEN     = 1'b0;
      bus.LD_CC      = 1'b0;
      bus.LD_REG     = 1'b0;
      bus.LD_PC      = 1'b0;
      bus.GatePC     = 1'b0;
      bus.GateMDR    = 1'b0;
      bus.GateALU    = 1'b0;
      bus.GateMARMUX = 1'b0;
      bus.DRMUX      = 1'b0;
      bus.SR1MUX     = 1'b0;
      bus.SR2MUX     = 1'b0;
      bus.ADDR1MUX   = 1'b0;
      bus.MIO_EN     = 1'b0;
      bus.PCMUX      = PCMUX_PC1;
      bus.ADDR2MUX   = ADDR2_ZERO;
      bus.ALUK       = ALUK_ADD;
      bus.Mem_CE     = 1'b0;
      bus.Mem_UB     = 1'b0;
      bus.Mem_LB     = 1'b0;
      bus.Mem_OE     = 1'b1;
      bus.Mem_WE     = 1'b1;
      case (r_state)
         ST_S18: begin
            bus.GatePC = 1'b1;
            bus.LD_MAR = 1'b1;
            bus.PCMUX  = PCMUX_PC1;
            bus.LD_PC  = 1'b1;
         end
         ST_S33, ST_S25: begin
            bus.MIO_EN = 1'b1;
            bus.Mem_OE = 1'b0;
            bus.LD_MDR = 1'b1;
         end
         ST_S35: begin
            bus.GateMDR = 1'b1;
            bus.LD_IR   = 1'b1;
         end
         ST_S32: bus.LD_BEN = 1'b1;
         ST_S1, ST_S5, ST_S9: begin
            bus.GateALU = 1'b1;
            bus.LD_REG  = 1'b1;
            bus.LD_CC   = 1'b1;
            bus.SR1MUX  = 1'b1;
            bus.SR2MUX  = bus.IR[5];
            bus.ALUK    = (r_state == ST_S1) ? ALUK_ADD :
                          (r_state == ST_S5) ? ALUK_AND : ALUK_NOT;
         end
         ST_S22: begin
            bus.PCMUX    = PCMUX_ADDR;
            bus.ADDR2MUX = ADDR2_OFF9;
            bus.LD_PC    = 1'b1;
         end
         ST_S12: begin
            bus.ADDR1MUX = 1'b1;
            bus.ADDR2MUX = ADDR2_ZERO;
            bus.SR1MUX   = 1'b1;
            bus.PCMUX    = PCMUX_ADDR;
            bus.LD_PC    = 1'b1;
         end
         ST_S4: begin
            bus.GatePC = 1'b1;
            bus.DRMUX  = 1'b1;
            bus.LD_REG = 1'b1;
         end
         ST_S21: begin
            bus.PCMUX    = PCMUX_ADDR;
            bus.ADDR2MUX = ADDR2_OFF11;
            bus.LD_PC    = 1'b1;
         end
         ST_S6, ST_S7: begin
            bus.GateMARMUX = 1'b1;
            bus.ADDR1MUX   = 1'b1;
            bus.ADDR2MUX   = ADDR2_OFF6;
            bus.SR1MUX     = 1'b1;
            bus.LD_MAR     = 1'b1;
         end
         ST_S27: begin
            bus.GateMDR = 1'b1;
            bus.LD_REG  = 1'b1;
            bus.LD_CC   = 1'b1;
         end
         ST_S23: begin
            bus.ALUK    = ALUK_PASSA;
            bus.GateALU = 1'b1;
            bus.LD_MDR  = 1'b1;
         end
         ST_S16: bus.Mem_WE = 1'b0;
         default: ;
      endcase
   end
endmodule

// File: tb/tb_lc3_control.sv
// tb/tb_lc3_control.sv - scoreboarded state-trace bench for lc3_control
module tb_lc3_control;
   import lc3_ctrl_pkg::*;

   typedef struct packed {
      logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc;
      logic gate_pc, gate_mdr, gate_alu, gate_marmux;
      logic drmux, sr1mux, sr2mux, addr1mux, mio_en;
      logic [1:0] pcmux, addr2mux, aluk;
      logic mem_oe, mem_we;
   } snap_t;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   n_ld_reg, n_ld_cc, n_ld_pc, n_oe_low, n_we_low;

   lc3_state_t exp_q[$];
   snap_t      snap [0:31];
   snap_t      snap_a, snap_b;

   lc3_control_if bus_a ();
   lc3_control_if bus_b ();

   lc3_control #(.MEM_WAIT(2)) dut  (.Clk(clk), .Reset(rst), .bus(bus_a));
   lc3_control #(.MEM_WAIT(0)) dut0 (.Clk(clk), .Reset(rst), .bus(bus_b));

   assign snap_a = {bus_a.LD_MAR, bus_a.LD_MDR, bus_a.LD_IR, bus_a.LD_BEN, bus_a.LD_CC, bus_a.LD_REG, bus_a.LD_PC,
                    bus_a.GatePC, bus_a.GateMDR, bus_a.GateALU, bus_a.GateMARMUX,
                    bus_a.DRMUX, bus_a.SR1MUX, bus_a.SR2MUX, bus_a.ADDR1MUX, bus_a.MIO_EN,
                    bus_a.PCMUX, bus_a.ADDR2MUX, bus_a.ALUK, bus_a.Mem_OE, bus_a.Mem_WE};
   assign snap_b = {bus_b.LD_MAR, bus_b.LD_MDR, bus_b.LD_IR, bus_b.LD_BEN, bus_b.LD_CC, bus_b.LD_REG, bus_b.LD_PC,
                    bus_b.GatePC, bus_b.GateMDR, bus_b.GateALU, bus_b.GateMARMUX,
                    bus_b.DRMUX, bus_b.SR1MUX, bus_b.SR2MUX, bus_b.ADDR1MUX, bus_b.MIO_EN,
                    bus_b.PCMUX, bus_b.ADDR2MUX, bus_b.ALUK, bus_b.Mem_OE, bus_b.Mem_WE};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_fetch(input int wait_cycles);
      exp_q.push_back(ST_S18);
      repeat (wait_cycles + 1) exp_q.push_back(ST_S33);
      exp_q.push_back(ST_S35);
`ifdef LC3_PAUSE_EN
      exp_q.push_back(ST_PAUSE_IR1);
      exp_q.push_back(ST_PAUSE_IR2);
`endif
      exp_q.push_back(ST_S32);
   endtask

   // Pops one expected state per clock and compares it with the live state of the chosen DUT.
   task automatic run_trace(input string tag, input int which);
      lc3_state_t e;
      lc3_state_t obs;
      snap_t      s;
      n_ld_reg = 0; n_ld_cc = 0; n_ld_pc = 0; n_oe_low = 0; n_we_low = 0;
      while (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         obs = (which == 0) ? dut.r_state : dut0.r_state;
         s   = (which == 0) ? snap_a : snap_b;
         chk({tag, "_state"}, 32'(obs), 32'(e));
         chk({tag, "_gate_onehot"}, 32'($countones({s.gate_pc, s.gate_mdr, s.gate_alu, s.gate_marmux}) <= 1), 32'd1);
         snap[int'(e)] = s;
         n_ld_reg += int'(s.ld_reg);
         n_ld_cc  += int'(s.ld_cc);
         n_ld_pc  += int'(s.ld_pc);
         n_oe_low += int'(!s.mem_oe);
         n_we_low += int'(!s.mem_we);
         if (which == 0) bus_a.Continue = (e == ST_PAUSE_IR1);
         else            bus_b.Continue = (e == ST_PAUSE_IR1);
         tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      bus_a.Run = 1'b0; bus_a.Continue = 1'b0; bus_a.IR = 16'h0000; bus_a.BEN = 1'b0;
      bus_b.Run = 1'b0; bus_b.Continue = 1'b0; bus_b.IR = 16'h0000; bus_b.BEN = 1'b0;
      tick(); tick();
      chk("reset_state", 32'(dut.r_state), 32'(ST_HALTED));
      chk("reset_oe_we", 32'({bus_a.Mem_OE, bus_a.Mem_WE}), 32'h3);
      chk("reset_ce_ub_lb", 32'({bus_a.Mem_CE, bus_a.Mem_UB, bus_a.Mem_LB}), 32'h0);
      rst = 1'b0;
      repeat (3) begin
         tick();
         chk("halt_hold", 32'(dut.r_state), 32'(ST_HALTED));
         chk("halt_no_load", 32'({snap_a.ld_mar, snap_a.ld_mdr, snap_a.ld_ir, snap_a.ld_ben,
                                  snap_a.ld_cc, snap_a.ld_reg, snap_a.ld_pc}), 32'h0);
      end

      // Store with single-cycle memory states on the MEM_WAIT=0 instance.
      bus_b.IR = 16'h7042; bus_b.Run = 1'b1;
      tick();
      bus_b.Run = 1'b0;
      push_fetch(0);
      exp_q.push_back(ST_S7); exp_q.push_back(ST_S23); exp_q.push_back(ST_S16);
      run_trace("str", 1);
      chk("str_we_low_cycles", 32'(n_we_low), 32'd1);
      chk("str_oe_low_cycles", 32'(n_oe_low), 32'd1);
      chk("str_s16_oe", 32'(snap[int'(ST_S16)].mem_oe), 32'd1);
      chk("str_s23_ctrl", 32'({snap[int'(ST_S23)].ld_mdr, snap[int'(ST_S23)].gate_alu,
                               snap[int'(ST_S23)].sr1mux, snap[int'(ST_S23)].aluk}), 32'b1_1_0_11);
      chk("str_return", 32'(dut0.r_state), 32'(ST_S18));

      bus_a.IR = 16'h1262; bus_a.Run = 1'b1;
      tick();
      bus_a.Run = 1'b0;
      push_fetch(2); exp_q.push_back(ST_S1);
      run_trace("add", 0);
      chk("add_ld_reg_cycles", 32'(n_ld_reg), 32'd1);
      chk("add_ld_cc_cycles", 32'(n_ld_cc), 32'd1);
      chk("add_ctrl", 32'({snap[int'(ST_S1)].sr2mux, snap[int'(ST_S1)].sr1mux, snap[int'(ST_S1)].gate_alu,
                           snap[int'(ST_S1)].drmux, snap[int'(ST_S1)].aluk}), 32'b1_1_1_0_00);
      chk("fetch_s35", 32'({snap[int'(ST_S35)].gate_mdr, snap[int'(ST_S35)].ld_ir}), 32'b11);
      chk("fetch_s32", 32'(snap[int'(ST_S32)].ld_ben), 32'd1);
      chk("fetch_s33", 32'({snap[int'(ST_S33)].mio_en, snap[int'(ST_S33)].ld_mdr, snap[int'(ST_S33)].mem_oe}), 32'b110);

      bus_a.IR = 16'h0E05; bus_a.BEN = 1'b1;
      push_fetch(2); exp_q.push_back(ST_S0); exp_q.push_back(ST_S22);
      run_trace("br_taken", 0);
      chk("br_s22_ctrl", 32'({snap[int'(ST_S22)].ld_pc, snap[int'(ST_S22)].pcmux,
                              snap[int'(ST_S22)].addr1mux, snap[int'(ST_S22)].addr2mux}), 32'b1_10_0_10);

      bus_a.BEN = 1'b0;
      push_fetch(2); exp_q.push_back(ST_S0);
      run_trace("br_not_taken", 0);
      chk("br_nt_s0_ld_pc", 32'(snap[int'(ST_S0)].ld_pc), 32'd0);
      chk("br_nt_ld_pc_cycles", 32'(n_ld_pc), 32'd1);

      bus_a.IR = 16'h6042;
      push_fetch(2);
      exp_q.push_back(ST_S6);
      repeat (3) exp_q.push_back(ST_S25);
      exp_q.push_back(ST_S27);
      run_trace("ldr", 0);
      chk("ldr_oe_low_cycles", 32'(n_oe_low), 32'd6);
      chk("ldr_s6_ctrl", 32'({snap[int'(ST_S6)].gate_marmux, snap[int'(ST_S6)].ld_mar,
                              snap[int'(ST_S6)].addr1mux, snap[int'(ST_S6)].addr2mux}), 32'b1_1_1_01);
      chk("ldr_s27_ctrl", 32'({snap[int'(ST_S27)].gate_mdr, snap[int'(ST_S27)].ld_reg,
                               snap[int'(ST_S27)].ld_cc, snap[int'(ST_S27)].drmux}), 32'b1_1_1_0);

      bus_a.IR = 16'h4000;
      push_fetch(2); exp_q.push_back(ST_S4); exp_q.push_back(ST_S21);
      run_trace("jsr", 0);
      chk("jsr_s4_ctrl", 32'({snap[int'(ST_S4)].gate_pc, snap[int'(ST_S4)].drmux, snap[int'(ST_S4)].ld_reg}), 32'b111);
      chk("jsr_s21_ctrl", 32'({snap[int'(ST_S21)].ld_pc, snap[int'(ST_S21)].pcmux, snap[int'(ST_S21)].addr2mux}), 32'b1_10_11);

      bus_a.IR = 16'hC1C0;
      push_fetch(2); exp_q.push_back(ST_S12);
      run_trace("jmp", 0);
      chk("jmp_s12_ctrl", 32'({snap[int'(ST_S12)].ld_pc, snap[int'(ST_S12)].pcmux, snap[int'(ST_S12)].addr1mux,
                               snap[int'(ST_S12)].addr2mux, snap[int'(ST_S12)].sr1mux}), 32'b1_10_1_00_1);

      bus_a.IR = 16'h927F;
      push_fetch(2); exp_q.push_back(ST_S9);
      run_trace("not", 0);
      chk("not_aluk", 32'(snap[int'(ST_S9)].aluk), 32'(ALUK_NOT));

      bus_a.IR = 16'hD0FF;
      push_fetch(2);
      run_trace("pause_op", 0);
`ifdef LC3_PAUSE_EN
      repeat (3) begin
         chk("pause1_hold", 32'(dut.r_state), 32'(ST_PAUSE1));
         tick();
      end
      bus_a.Continue = 1'b1;
      repeat (3) begin
         tick();
         chk("pause2_hold", 32'(dut.r_state), 32'(ST_PAUSE2));
      end
      bus_a.Continue = 1'b0;
      tick();
`endif
      chk("pause_op_return", 32'(dut.r_state), 32'(ST_S18));

      bus_a.IR = 16'h8000;
      push_fetch(2);
      run_trace("nop", 0);

      // Asynchronous reset in the second cycle of the instruction read.
      tick(); tick();
      chk("pre_reset_s33", 32'(dut.r_state), 32'(ST_S33));
      rst = 1'b1;
      #1;
      chk("async_reset_state", 32'(dut.r_state), 32'(ST_HALTED));
      chk("async_reset_oe", 32'(bus_a.Mem_OE), 32'd1);
      chk("async_reset_ld_mdr", 32'(bus_a.LD_MDR), 32'd0);
      chk("async_reset_timer", 32'(dut.u_timer.r_count), 32'd0);
      tick();
      rst = 1'b0;
      repeat (2) begin
         tick();
         chk("post_reset_halt", 32'(dut.r_state), 32'(ST_HALTED));
         chk("post_reset_no_load", 32'({snap_a.ld_mar, snap_a.ld_mdr, snap_a.ld_ir, snap_a.ld_ben,
                                        snap_a.ld_cc, snap_a.ld_reg, snap_a.ld_pc}), 32'h0);
      end

      bus_a.IR = 16'h5020; bus_a.Run = 1'b1;
      tick();
      bus_a.Run = 1'b0;
      push_fetch(2); exp_q.push_back(ST_S5);
      run_trace("and", 0);
      chk("and_ctrl", 32'({snap[int'(ST_S5)].sr2mux, snap[int'(ST_S5)].aluk}), 32'b1_01);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
